ps2_key_decoder: RTL and testbench

- Receives raw PS/2 keyboard clock/data and emits the single-cycle key event interface used by the arcade top levels: `key_strobe`, `key_pressed`, `key_code`, plus `key_extended`.
- It is the producing end of the key event bus consumed by the `btn_*` capture logic.
- It frames 11-bit PS/2 packets, checks parity, and folds the E0 (extended) and F0 (break) prefixes into a single make/break event per key.

---
 rtl/ps2_key_decoder.sv | 142 ++++++++++++++
 tb/tb_ps2_key_decoder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: conditions the raw PS/2 lines, frames 11-bit packets and folds
// E0/F0 prefixes into single make/break key events for the btn_* capture logic.
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 11000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_strobe,
  output logic       key_pressed,
  output logic       key_extended,
  output logic [7:0] key_code,
  output logic       frame_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TLIMIT = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic                  clk_s1, clk_s2, data_s1, data_s2;
  logic [FILTER_LEN-2:0] samples;
  logic [FILTER_LEN-1:0] window;
  logic                  filt, filt_d;
  logic                  fall;

  state_t                state;
  logic [2:0]            bit_cnt;
  logic [7:0]            shift;
  logic                  ok;
  logic                  ext_flag, brk_flag;
  logic [TW-1:0]         tcnt;

  // The window includes the newest synchronized sample so the filter decides in the same
  // cycle the last equal sample arrives.
  assign window = {samples, clk_s2};
  assign fall   = filt_d & ~filt;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
      samples <= '1;
      filt    <= 1'b1;
      filt_d  <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
      samples <= window[FILTER_LEN-2:0];
      if (window == '0) begin
        filt <= 1'b0;
      end else if (window == '1) begin
        filt <= 1'b1;
      end
      filt_d <= filt;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      bit_cnt      <= 3'd0;
      shift        <= 8'h00;
      ok           <= 1'b0;
      ext_flag     <= 1'b0;
      brk_flag     <= 1'b0;
      tcnt         <= '0;
      key_strobe   <= 1'b0;
      frame_error  <= 1'b0;
      key_code     <= 8'h00;
      key_pressed  <= 1'b0;
      key_extended <= 1'b0;
    end else begin
      key_strobe  <= 1'b0;
      frame_error <= 1'b0;
      if (fall) begin
        tcnt <= '0;
        case (state)
          IDLE: begin
            if (!data_s2) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end
          end
          DATA: begin
            shift   <= {data_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            ok    <= ^{shift, data_s2};
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (data_s2 && ok) begin
              if (shift == 8'hE0) begin
                ext_flag <= 1'b1;
              end else if (shift == 8'hF0) begin
                brk_flag <= 1'b1;
              end else begin
                key_strobe   <= 1'b1;
                key_code     <= shift;
                key_pressed  <= ~brk_flag;
                key_extended <= ext_flag;
                ext_flag     <= 1'b0;
                brk_flag     <= 1'b0;
              end
            end else begin
              frame_error <= 1'b1;
              ext_flag    <= 1'b0;
              brk_flag    <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        // A stalled frame is dropped along with any prefix it may have been part of.
        if (tcnt == TLIMIT) begin
          state       <= IDLE;
          tcnt        <= '0;
          frame_error <= 1'b1;
          ext_flag    <= 1'b0;
          brk_flag    <= 1'b0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end else begin
        tcnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: table-driven PS/2 frames feeding a scoreboard,
// plus hand-written timeout, glitch and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_ps2_key_decoder;

  localparam int FL   = 8;
  localparam int TO   = 600;
  localparam int HALF = 40;

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_strobe, key_pressed, key_extended, frame_error;
  logic [7:0] key_code;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       err;
    logic [7:0] code;
    logic       pressed;
    logic       ext;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       bad_par;
    logic       bad_stop;
    int         gap;
    logic       exp_ev;
    logic       exp_err;
    logic [7:0] exp_code;
    logic       exp_pressed;
    logic       exp_ext;
  } vec_t;

  ev_t  exp_q[$];
  vec_t vecs[19];

  ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .key_strobe(key_strobe),
    .key_pressed(key_pressed),
    .key_extended(key_extended),
    .key_code(key_code),
    .frame_error(frame_error)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Sends the first nbits of a frame (start, 8 data LSB-first, odd parity, stop); an optional
  // short low glitch is placed in the high phase before bit glitch_bit's falling edge.
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                            input int glitch_bit, input int nbits);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk_sys);
      ps2_data = bits[i];
      if (i == glitch_bit) begin
        wait_cycles(10);
        ps2_clk = 1'b0;
        wait_cycles(FL - 1);
        ps2_clk = 1'b1;
        wait_cycles(HALF - 10 - (FL - 1));
      end else begin
        wait_cycles(HALF);
      end
      ps2_clk = 1'b0;
      wait_cycles(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic push_event(input logic err, input logic [7:0] code, input logic pressed, input logic ext);
    ev_t e;
    e.err = err; e.code = code; e.pressed = pressed; e.ext = ext;
    exp_q.push_back(e);
  endtask

  task automatic apply_stimulus(input vec_t v);
    if (v.exp_ev) push_event(v.exp_err, v.exp_code, v.exp_pressed, v.exp_ext);
    send_frame(v.data, v.bad_par, v.bad_stop, -1, 11);
    wait_cycles(v.gap);
  endtask

  // Scoreboard consumer: every cycle with an event must match the oldest expectation.
  always @(negedge clk_sys) begin
    if (!reset && (key_strobe || frame_error)) begin
      check_output("strobe_err_exclusive", {7'b0, key_strobe & frame_error}, 8'h00);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_event actual strobe=%0b err=%0b code=%0h expected none",
                 key_strobe, frame_error, key_code);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check_output("event_is_error", {7'b0, frame_error}, {7'b0, e.err});
        if (!e.err) begin
          check_output("key_code", key_code, e.code);
          check_output("key_pressed", {7'b0, key_pressed}, {7'b0, e.pressed});
          check_output("key_extended", {7'b0, key_extended}, {7'b0, e.ext});
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{8'h29, 0, 0, 20, 1, 0, 8'h29, 1, 0};
    vecs[1]  = '{8'hF0, 0, 0, 0,  0, 0, 8'h00, 0, 0};
    vecs[2]  = '{8'h29, 0, 0, 20, 1, 0, 8'h29, 0, 0};
    vecs[3]  = '{8'hE0, 0, 0, 0,  0, 0, 8'h00, 0, 0};
    vecs[4]  = '{8'h75, 0, 0, 20, 1, 0, 8'h75, 1, 1};
    vecs[5]  = '{8'hE0, 0, 0, 0,  0, 0, 8'h00, 0, 0};
    vecs[6]  = '{8'hF0, 0, 0, 0,  0, 0, 8'h00, 0, 0};
    vecs[7]  = '{8'h75, 0, 0, 20, 1, 0, 8'h75, 0, 1};
    vecs[8]  = '{8'hF0, 0, 0, 0,  0, 0, 8'h00, 0, 0};
    vecs[9]  = '{8'h6B, 1, 0, 20, 1, 1, 8'h00, 0, 0};
    vecs[10] = '{8'h6B, 0, 0, 20, 1, 0, 8'h6B, 1, 0};
    vecs[11] = '{8'hE1, 0, 0, 20, 1, 0, 8'hE1, 1, 0};
    vecs[12] = '{8'hE0, 0, 0, 0,  0, 0, 8'h00, 0, 0};
    vecs[13] = '{8'h1C, 0, 1, 20, 1, 1, 8'h00, 0, 0};
    vecs[14] = '{8'h1C, 0, 0, 20, 1, 0, 8'h1C, 1, 0};
    vecs[15] = '{8'hE0, 0, 0, 0,  0, 0, 8'h00, 0, 0};
    vecs[16] = '{8'h12, 0, 0, 0,  1, 0, 8'h12, 1, 1};
    vecs[17] = '{8'hF0, 0, 0, 0,  0, 0, 8'h00, 0, 0};
    vecs[18] = '{8'h12, 0, 0, 20, 1, 0, 8'h12, 0, 0};

    wait_cycles(5);
    check_output("reset_strobe", {7'b0, key_strobe}, 8'h00);
    check_output("reset_error", {7'b0, frame_error}, 8'h00);
    check_output("reset_code", key_code, 8'h00);
    check_output("reset_pressed", {7'b0, key_pressed}, 8'h00);
    check_output("reset_extended", {7'b0, key_extended}, 8'h00);
    reset = 1'b0;
    wait_cycles(30);

    for (int i = 0; i < 19; i++) apply_stimulus(vecs[i]);
    wait_cycles(100);
    check_output("table_drained", 8'(exp_q.size()), 8'h00);

    // Stalled frame: start plus four data bits, then silence beyond the timeout.
    push_event(1'b1, 8'h00, 1'b0, 1'b0);
    send_frame(8'h05, 1'b0, 1'b0, -1, 5);
    wait_cycles(TO + 100);
    check_output("timeout_drained", 8'(exp_q.size()), 8'h00);
    push_event(1'b0, 8'h05, 1'b1, 1'b0);
    send_frame(8'h05, 1'b0, 1'b0, -1, 11);
    wait_cycles(50);

    // Short low glitch inside a frame must not shift an extra bit.
    push_event(1'b0, 8'h5A, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b0, 3, 11);
    wait_cycles(50);
    check_output("glitch_drained", 8'(exp_q.size()), 8'h00);

    // Asynchronous reset in the middle of the data bits.
    send_frame(8'h3C, 1'b0, 1'b0, -1, 4);
    @(posedge clk_sys);
    #3 reset = 1'b1;
    #1;
    check_output("midreset_strobe", {7'b0, key_strobe}, 8'h00);
    check_output("midreset_error", {7'b0, frame_error}, 8'h00);
    check_output("midreset_code", key_code, 8'h00);
    check_output("midreset_pressed", {7'b0, key_pressed}, 8'h00);
    check_output("midreset_extended", {7'b0, key_extended}, 8'h00);
    wait_cycles(5);
    reset = 1'b0;
    wait_cycles(50);
    push_event(1'b0, 8'h3C, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, -1, 11);

    wait_cycles(200);
    check_output("final_drained", 8'(exp_q.size()), 8'h00);
    check_output("held_code", key_code, 8'h3C);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
